// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   master : datapath side. Drives the ID-stage fields and the EX status, and reads the controls.
//   slave  : the hazard controller itself.
// ID fields  : id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_reg_write, id_mem_read
// EX status  : ex_branch_taken, ex_busy
// Controls   : pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_bubble,
//              fwd_a/b, id_bypass_a/b
// Counters   : stall_cnt, flush_cnt
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              ex_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_hold;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;
  logic              id_bypass_a;
  logic              id_bypass_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken, ex_busy,
    input  pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_bubble,
           fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken, ex_busy,
    output pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_bubble,
           fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing unit. It keeps a scoreboard that shadows the post-ID pipeline
// registers, where idx0 is ID/EX and idx DEPTH-1 is MEM/WB. From that scoreboard it derives
// the stall, flush and bubble controls, the EX forwarding selects and the ID write-back
// bypass. It also counts stall and flush cycles in saturating counters.
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous, active-low reset.
//   hz  : slave side of pipeline_hazard_ctrl_if. Its parameters must match the parameters of
//         this module.
// Cycle modes, in priority order:
//   busy     | multi-cycle op in idx0. The front end and idx0 are frozen and idx1 is bubbled.
//   flush    | taken branch in idx0. IF/ID and ID/EX are squashed.
//   load_use | ID needs a load result that cannot be forwarded yet. ID/EX is bubbled.
//   normal   | everything advances.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 3,
  parameter int LOAD_FWD_IDX = 2,
  parameter int FWD_W        = 3,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } entry_t;

  entry_t [DEPTH-1:0] sb_q, sb_d;
  logic   [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic   [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [DEPTH-1:0] live;
  logic             load_use;
  logic             busy;
  logic             flush;
  logic             lu_stall;

  // The youngest matching producer wins. If that producer is a load that is still too young
  // to forward, the select falls back to the register value; the load-use stall prevents
  // this case from occurring.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                               input logic [DEPTH-1:0]  lv,
                                               input entry_t [DEPTH-1:0] sb);
    logic [FWD_W-1:0] sel;
    logic             young_load;
    sel        = '0;
    young_load = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (lv[k] && (sb[k].rd == rs)) begin
        sel        = FWD_W'(k);
        young_load = (k < LOAD_FWD_IDX) && sb[k].mem_read;
      end
    end
    return young_load ? '0 : sel;
  endfunction

  always_comb begin
    live     = '0;
    load_use = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      live[k] = sb_q[k].valid && sb_q[k].reg_write && (sb_q[k].rd != '0);
    end
    for (int j = 0; j < DEPTH; j++) begin
      if ((j + 1 < LOAD_FWD_IDX) && live[j] && sb_q[j].mem_read) begin
        if ((hz.id_valid && hz.id_use_rs1 && (hz.id_rs1 == sb_q[j].rd)) ||
            (hz.id_valid && hz.id_use_rs2 && (hz.id_rs2 == sb_q[j].rd))) begin
          load_use = 1'b1;
        end
      end
    end
    busy     = hz.ex_busy && sb_q[0].valid;
    flush    = hz.ex_branch_taken && sb_q[0].valid && !busy;
    lu_stall = load_use && !busy && !flush;
  end

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_hold    = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_bubble = 1'b0;
    if (busy) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.idex_hold    = 1'b1;
      hz.exmem_bubble = 1'b1;
    end else if (flush) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (lu_stall) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end

    hz.fwd_a = (sb_q[0].valid && sb_q[0].use_rs1) ? fwd_sel(sb_q[0].rs1, live, sb_q) : '0;
    hz.fwd_b = (sb_q[0].valid && sb_q[0].use_rs2) ? fwd_sel(sb_q[0].rs2, live, sb_q) : '0;

    hz.id_bypass_a = hz.id_valid && hz.id_use_rs1 && live[DEPTH-1] &&
                     (sb_q[DEPTH-1].rd == hz.id_rs1);
    hz.id_bypass_b = hz.id_valid && hz.id_use_rs2 && live[DEPTH-1] &&
                     (sb_q[DEPTH-1].rd == hz.id_rs2);
  end

  always_comb begin
    sb_d = sb_q;
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (busy) begin
      sb_d[0] = sb_q[0];
      sb_d[1] = '0;
    end else if (flush || lu_stall) begin
      sb_d[0] = '0;
    end else begin
      sb_d[0].valid     = hz.id_valid;
      sb_d[0].rd        = hz.id_rd;
      sb_d[0].reg_write = hz.id_reg_write;
      sb_d[0].mem_read  = hz.id_mem_read;
      sb_d[0].rs1       = hz.id_rs1;
      sb_d[0].rs2       = hz.id_rs2;
      sb_d[0].use_rs1   = hz.id_use_rs1;
      sb_d[0].use_rs2   = hz.id_use_rs2;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((busy || lu_stall) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))              flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. It uses DEPTH=3, LOAD_FWD_IDX=2 and CNT_W=4, so
// the counter saturation can be reached in a short run.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int LFI    = 2;
  localparam int FWD_W  = 3;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .FWD_W(FWD_W), .CNT_W(CNT_W)) hz();

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_FWD_IDX(LFI), .FWD_W(FWD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    hz.id_valid     = v;
    hz.id_rs1       = rs1;
    hz.id_rs2       = rs2;
    hz.id_use_rs1   = u1;
    hz.id_use_rs2   = u2;
    hz.id_rd        = rd;
    hz.id_reg_write = rw;
    hz.id_mem_read  = mr;
  endtask

  task automatic set_idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    hz.ex_busy         = 1'b0;
    hz.ex_branch_taken = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_write"},     32'(hz.pc_write),     32'd1);
    chk({tag, "_ifid_write"},   32'(hz.ifid_write),   32'd1);
    chk({tag, "_ifid_flush"},   32'(hz.ifid_flush),   32'd0);
    chk({tag, "_idex_hold"},    32'(hz.idex_hold),    32'd0);
    chk({tag, "_idex_bubble"},  32'(hz.idex_bubble),  32'd0);
    chk({tag, "_exmem_bubble"}, 32'(hz.exmem_bubble), 32'd0);
    chk({tag, "_fwd_a"},        32'(hz.fwd_a),        32'd0);
    chk({tag, "_fwd_b"},        32'(hz.fwd_b),        32'd0);
    chk({tag, "_stall_cnt"},    32'(hz.stall_cnt),    32'd0);
    chk({tag, "_flush_cnt"},    32'(hz.flush_cnt),    32'd0);
  endtask

  // Assert reset with whatever inputs are current, check outputs after 1 ns, then release.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk_reset(tag);
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    hz.ex_busy         = 1'b1;
    hz.ex_branch_taken = 1'b1;
    #2;
    chk_reset("rst_init");
    chk("rst_init_bypass_a", 32'(hz.id_bypass_a), 32'd0);
    do_reset("rst0");

    // 1: lw x5 followed by add x6,x5,x7.
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    #1 chk("t1_lw_pc_write", 32'(hz.pc_write), 32'd1);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("t1_lu_pc_write",   32'(hz.pc_write),    32'd0);
    chk("t1_lu_ifid_write", 32'(hz.ifid_write),  32'd0);
    chk("t1_lu_bubble",     32'(hz.idex_bubble), 32'd1);
    chk("t1_lu_hold",       32'(hz.idex_hold),   32'd0);
    chk("t1_lu_cnt_pre",    32'(hz.stall_cnt),   32'd0);
    tick();
    chk("t1_after_pc_write", 32'(hz.pc_write),    32'd1);
    chk("t1_after_bubble",   32'(hz.idex_bubble), 32'd0);
    chk("t1_stall_cnt",      32'(hz.stall_cnt),   32'd1);
    tick();
    set_id(1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    chk("t1_fwd_a",     32'(hz.fwd_a),       32'd2);
    chk("t1_fwd_b",     32'(hz.fwd_b),       32'd0);
    chk("t1_bypass_a",  32'(hz.id_bypass_a), 32'd0);
    chk("t1_bypass_b",  32'(hz.id_bypass_b), 32'd1);
    tick();
    do_reset("t2_rst");

    // 2: add x5 followed by sub x8,x5,x5.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    chk("t2_pc_write", 32'(hz.pc_write),    32'd1);
    chk("t2_bubble",   32'(hz.idex_bubble), 32'd0);
    tick();
    set_idle();
    #1;
    chk("t2_fwd_a", 32'(hz.fwd_a), 32'd1);
    chk("t2_fwd_b", 32'(hz.fwd_b), 32'd1);
    tick();
    chk("t2_inv_idx0_fwd_a", 32'(hz.fwd_a), 32'd0);
    do_reset("t3_rst");

    // 3: two writers of x5 (idx1 and idx2); x0 never forwards.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    set_idle();
    #1;
    chk("t3_fwd_a_youngest", 32'(hz.fwd_a), 32'd1);
    chk("t3_fwd_b_x0",       32'(hz.fwd_b), 32'd0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("t3_bypass_a",    32'(hz.id_bypass_a), 32'd1);
    chk("t3_bypass_pc",   32'(hz.pc_write),    32'd1);
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("t3_bypass_nouse", 32'(hz.id_bypass_a), 32'd0);
    do_reset("t4_rst");

    // 4: taken branch in idx0 while a load-use hazard is pending in ID.
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    hz.ex_branch_taken = 1'b1;
    #1;
    chk("t4_ifid_flush", 32'(hz.ifid_flush),  32'd1);
    chk("t4_bubble",     32'(hz.idex_bubble), 32'd1);
    chk("t4_pc_write",   32'(hz.pc_write),    32'd1);
    chk("t4_ifid_write", 32'(hz.ifid_write),  32'd1);
    tick();
    chk("t4_flush_cnt",      32'(hz.flush_cnt),  32'd1);
    chk("t4_stall_cnt",      32'(hz.stall_cnt),  32'd0);
    chk("t4_inv_idx0_flush", 32'(hz.ifid_flush), 32'd0);
    chk("t4_after_pc_write", 32'(hz.pc_write),   32'd1);
    tick();
    chk("t4_flush_cnt_hold", 32'(hz.flush_cnt), 32'd1);
    hz.ex_branch_taken = 1'b0;
    do_reset("t5_rst");

    // 5: busy for 3 cycles with a taken branch; the flush follows once busy drops.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    hz.ex_busy         = 1'b1;
    hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] exp_fwd;
      exp_fwd = (i == 0) ? 3'd1 : ((i == 1) ? 3'd2 : 3'd0);
      #1;
      chk("t5_busy_pc_write",  32'(hz.pc_write),     32'd0);
      chk("t5_busy_ifid_wr",   32'(hz.ifid_write),   32'd0);
      chk("t5_busy_hold",      32'(hz.idex_hold),    32'd1);
      chk("t5_busy_exmem_bub", 32'(hz.exmem_bubble), 32'd1);
      chk("t5_busy_no_flush",  32'(hz.ifid_flush),   32'd0);
      chk("t5_busy_fwd_a",     32'(hz.fwd_a),        32'(exp_fwd));
      tick();
    end
    chk("t5_stall_cnt", 32'(hz.stall_cnt), 32'd3);
    hz.ex_busy = 1'b0;
    #1;
    chk("t5_flush",    32'(hz.ifid_flush),  32'd1);
    chk("t5_bubble",   32'(hz.idex_bubble), 32'd1);
    chk("t5_pc_write", 32'(hz.pc_write),    32'd1);
    chk("t5_no_hold",  32'(hz.idex_hold),   32'd0);
    tick();
    chk("t5_flush_cnt",  32'(hz.flush_cnt), 32'd1);
    chk("t5_stall_hold", 32'(hz.stall_cnt), 32'd3);
    hz.ex_branch_taken = 1'b0;
    do_reset("t6_rst");

    // 6: 20 load-use stalls saturate the 4-bit counter; then reset is asserted mid-stall.
    for (int i = 1; i <= 20; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
      #1 chk("t6_stall_pc_write", 32'(hz.pc_write), 32'd0);
      tick();
      chk("t6_stall_cnt", 32'(hz.stall_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 chk("t6_midstall_pc_write", 32'(hz.pc_write), 32'd0);
    do_reset("t6_midstall");
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 chk("t6_first_normal", 32'(hz.pc_write), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised pipeline sequencing unit for the RISC-V core. It replaces the separate load-use hazard detection and forwarding units with one block that keeps its own scoreboard of in-flight instructions.
- Stall, flush and bubble controls and forwarding selects are derived from that scoreboard, for a configurable number of post-ID stages.
- New capabilities: branch flush of IF/ID and ID/EX, multi-cycle EX busy stall, ID-stage write-back bypass, saturating stall/flush counters.

Parameters:
REG_AW, 5, register address width; address 0 is never a hazard or forward source.
DEPTH, 3, tracked pipeline registers after ID: idx0=ID/EX, idx1=EX/MEM, ..., idx DEPTH-1=MEM/WB; range 2..6.
LOAD_FWD_IDX, 2, lowest idx where a load result may be forwarded; range 1..DEPTH-1.
FWD_W, 3, width of forward selects; must satisfy 2^FWD_W > DEPTH-1.
CNT_W, 16, performance counter width.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
id_valid  in  1  ID holds a real instruction.
id_rs1, id_rs2  in  REG_AW  ID source registers.
id_use_rs1, id_use_rs2  in  1  the source is actually read.
id_rd  in  REG_AW  ID destination register.
id_reg_write, id_mem_read  in  1  ID control bits.
ex_branch_taken  in  1  branch in idx0 resolved taken this cycle.
ex_busy  in  1  multi-cycle EX op in idx0 not finished.
pc_write  out  1  PC update enable.
ifid_write  out  1  IF/ID load enable.
ifid_flush  out  1  IF/ID load a NOP.
idex_hold  out  1  ID/EX keeps its contents.
idex_bubble  out  1  ID/EX load zero controls.
exmem_bubble  out  1  EX/MEM load zero controls.
fwd_a, fwd_b  out  FWD_W  EX operand select: 0 = ID/EX register value, k = result at idx k.
id_bypass_a, id_bypass_b  out  1  ID operand takes the write-back data (idx DEPTH-1).
stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Scoreboard: per idx, the fields valid, rd, reg_write, mem_read, rs1, rs2, use_rs1, use_rs2. Cleared to invalid on reset.
- Controls are combinational from the scoreboard and inputs. Scoreboard and counters update on the rising clk edge, in lockstep with the real pipeline registers.
- Reset values (rst low, asynchronous): all entries invalid, counters 0, pc_write=1, ifid_write=1, all other outputs 0.
- "live(k)" means entry k has valid & reg_write & rd!=0.
- Load-use hazard: exists if, for some j with j+1<LOAD_FWD_IDX, live(j) & mem_read(j), and id_valid & use_rsX & rsX==rd(j).
- Priority: busy > flush > load-use > normal.
  - BUSY (ex_busy & valid(0)):
    - Outputs: pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1.
    - Scoreboard: idx0 held; idx1 becomes invalid; idx>=2 shift.
    - ex_branch_taken is ignored while busy.
  - FLUSH (ex_branch_taken & valid(0)):
    - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
    - Scoreboard: all shift; new idx0 is invalid.
    - Any concurrent load-use hazard is discarded.
  - LOAD-USE:
    - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
    - Scoreboard: all shift; new idx0 is invalid.
  - NORMAL:
    - Outputs: pc_write=1, ifid_write=1.
    - Scoreboard: all shift; idx0 loads the ID fields, with valid=id_valid.
- Forwarding for operand X of idx0:
  - Applies only when valid(0) & use_rsX(0).
  - Select the smallest k in 1..DEPTH-1 with live(k) & rd(k)==rsX(0); fwd=k, else 0.
  - The youngest producer wins when several entries match.
  - A match at k<LOAD_FWD_IDX with mem_read(k) is unreachable by construction; output fwd=0 in that case.
- ID bypass: id_bypass_X=1 if id_valid & use_rsX & live(DEPTH-1) & rd(DEPTH-1)==id_rsX.
- Register address 0 never stalls, forwards or bypasses.
- Counters:
  - stall_cnt +1 per BUSY or LOAD-USE cycle.
  - flush_cnt +1 per FLUSH cycle.
  - Both saturate at all-ones; no wrap.
- An invalid idx0 never triggers busy or flush, even if ex_busy or ex_branch_taken is high.
- Reset asserted mid-stall or mid-busy clears everything immediately.
- The first cycle after reset release is NORMAL.

Test Plan:
1. lw x5 in ID then add x6,x5,x7 in ID (defaults) -> one LOAD-USE cycle (pc_write=0, idex_bubble=1, stall_cnt=1); two cycles later fwd_a=2.
2. add x5 then sub x8,x5,x5 back-to-back -> no stall; fwd_a=fwd_b=1 when sub is in idx0.
3. x5 written by entries at idx1 and idx2 together -> fwd_a=1 (youngest wins).
4. Taken branch in idx0 with a load-use hazard pending in ID -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
5. ex_busy high for 3 cycles with ex_branch_taken=1 -> 3 cycles of pc_write=0, idex_hold=1, exmem_bubble=1; flush only in the cycle after busy drops; stall_cnt=3.
6. CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 15; assert rst low mid-stall -> all outputs at reset values immediately.
